// File: rtl/ps2_key_event.sv
// ps2_key_event
//   Turns a stream of PS/2 set-2 scancode bytes into key events
//   {ext, release, code} and queues them in a show-ahead FIFO.
//   Prefix bytes (E0, F0), the eight-byte Pause sequence and keyboard
//   housekeeping replies are absorbed by the parser. Optionally,
//   typematic repeat makes of the held key are suppressed.
//
// Parameters
//   DEPTH           event FIFO depth (power of two, 2..16)
//   SUPPRESS_REPEAT 1 drops typematic repeat makes
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   scancode   in   received PS/2 byte, valid while flag is high
//   flag       in   one-cycle strobe per received byte
//   ev_ready   in   consumer pop request
//   ev_valid   out  FIFO non-empty
//   ev_code    out  head event key code
//   ev_ext     out  head event carried an E0 prefix
//   ev_release out  head event is a break
//   count      out  FIFO occupancy (0..DEPTH)
//   overflow   out  sticky, an event was dropped on a full FIFO
module ps2_key_event #(
  parameter int DEPTH           = 4,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               scancode,
  input  logic                     flag,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_release,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GOT_E0   = 3'd1,
    GOT_F0   = 3'd2,
    GOT_E0F0 = 3'd3,
    PAUSE    = 3'd4
  } state_t;

  // Keyboard replies and error codes that never describe a key.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  state_t      state_r;
  logic [2:0]  skip_r;
  logic        hv_r;
  logic        hext_r;
  logic [7:0]  hcode_r;
  logic        pend_v_r;
  logic        pend_ext_r;
  logic        pend_rel_r;
  logic [7:0]  pend_code_r;

  state_t      next_state_s;
  logic [2:0]  next_skip_s;
  logic        cand_v_s;
  logic        cand_ext_s;
  logic        cand_rel_s;
  logic        cand_pause_s;
  logic [7:0]  cand_code_s;
  logic        match_s;
  logic        emit_s;

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] rd_r;
  logic [AW-1:0] wr_r;
  logic [AW-1:0] next_rd_s;
  logic [CW-1:0] next_count_s;
  logic [9:0]    next_head_s;
  logic [9:0]    pend_word_s;
  logic          pop_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;

  // Byte decode: next parser state and the candidate event for this byte.
  always_comb begin
    next_state_s = state_r;
    next_skip_s  = skip_r;
    cand_v_s     = 1'b0;
    cand_ext_s   = 1'b0;
    cand_rel_s   = 1'b0;
    cand_pause_s = 1'b0;
    cand_code_s  = scancode;
    case (state_r)
      IDLE: begin
        if (scancode == 8'hE0) begin
          next_state_s = GOT_E0;
        end else if (scancode == 8'hF0) begin
          next_state_s = GOT_F0;
        end else if (scancode == 8'hE1) begin
          next_state_s = PAUSE;
          next_skip_s  = 3'd0;
        end else if (is_noise(scancode)) begin
          next_state_s = IDLE;
        end else begin
          cand_v_s = 1'b1;
        end
      end
      GOT_E0: begin
        if (scancode == 8'hF0) begin
          next_state_s = GOT_E0F0;
        end else if (scancode == 8'hE0) begin
          next_state_s = GOT_E0;
        end else begin
          cand_v_s     = 1'b1;
          cand_ext_s   = 1'b1;
          next_state_s = IDLE;
        end
      end
      GOT_F0: begin
        if (scancode == 8'hF0) begin
          next_state_s = GOT_F0;
        end else if (scancode == 8'hE0) begin
          next_state_s = GOT_E0;
        end else begin
          cand_v_s     = 1'b1;
          cand_rel_s   = 1'b1;
          next_state_s = IDLE;
        end
      end
      GOT_E0F0: begin
        if ((scancode == 8'hE0) || (scancode == 8'hF0)) begin
          next_state_s = GOT_E0F0;
        end else begin
          cand_v_s     = 1'b1;
          cand_ext_s   = 1'b1;
          cand_rel_s   = 1'b1;
          next_state_s = IDLE;
        end
      end
      PAUSE: begin
        // The seven bytes after E1 are swallowed; the last one reports Pause.
        if (skip_r == 3'd6) begin
          cand_v_s     = 1'b1;
          cand_pause_s = 1'b1;
          cand_code_s  = 8'hE1;
          next_skip_s  = 3'd0;
          next_state_s = IDLE;
        end else begin
          next_skip_s = skip_r + 3'd1;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_skip_s  = 3'd0;
      end
    endcase
  end

  // Repeat filter: a make of the currently held key is a typematic repeat.
  // Pause has no break code, so it bypasses the held-key tracking.
  always_comb begin
    match_s = hv_r && (hext_r == cand_ext_s) && (hcode_r == cand_code_s);
    if (SUPPRESS_REPEAT && !cand_rel_s && !cand_pause_s && match_s) begin
      emit_s = 1'b0;
    end else begin
      emit_s = cand_v_s;
    end
  end

  // Parser FSM, held-key register and the one-deep pending write stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      skip_r      <= 3'd0;
      hv_r        <= 1'b0;
      hext_r      <= 1'b0;
      hcode_r     <= 8'h00;
      pend_v_r    <= 1'b0;
      pend_ext_r  <= 1'b0;
      pend_rel_r  <= 1'b0;
      pend_code_r <= 8'h00;
    end else begin
      // Flags are at least two cycles apart, so the pending stage always
      // drains into the FIFO before it can be reloaded.
      pend_v_r <= flag && emit_s;
      if (flag) begin
        state_r     <= next_state_s;
        skip_r      <= next_skip_s;
        pend_ext_r  <= cand_ext_s;
        pend_rel_r  <= cand_rel_s;
        pend_code_r <= cand_code_s;
        if (SUPPRESS_REPEAT && emit_s && !cand_pause_s) begin
          if (!cand_rel_s) begin
            hv_r    <= 1'b1;
            hext_r  <= cand_ext_s;
            hcode_r <= cand_code_s;
          end else if (match_s) begin
            hv_r <= 1'b0;
          end
        end
      end
    end
  end

  // FIFO control: push/pop decisions and the next show-ahead head word.
  always_comb begin
    pend_word_s = {pend_ext_r, pend_rel_r, pend_code_r};
    pop_s       = ev_valid && ev_ready;
    full_s      = (count == FULL_CNT);
    push_s      = pend_v_r && (!full_s || pop_s);
    drop_s      = pend_v_r && full_s && !pop_s;
    if (pop_s) begin
      next_rd_s = rd_r + AW'(1);
    end else begin
      next_rd_s = rd_r;
    end
    case ({push_s, pop_s})
      2'b10:   next_count_s = count + CW'(1);
      2'b01:   next_count_s = count - CW'(1);
      default: next_count_s = count;
    endcase
    // An entry written this edge into the next head slot is not in mem_r yet.
    if (push_s && (wr_r == next_rd_s)) begin
      next_head_s = pend_word_s;
    end else begin
      next_head_s = mem_r[next_rd_s];
    end
  end

  // FIFO storage; contents only matter once counted as occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_r] <= pend_word_s;
    end
  end

  // FIFO pointers, occupancy, registered head outputs and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_r       <= '0;
      wr_r       <= '0;
      count      <= '0;
      ev_valid   <= 1'b0;
      ev_ext     <= 1'b0;
      ev_release <= 1'b0;
      ev_code    <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      rd_r  <= next_rd_s;
      wr_r  <= push_s ? (wr_r + AW'(1)) : wr_r;
      count <= next_count_s;
      ev_valid <= (next_count_s != '0);
      {ev_ext, ev_release, ev_code} <= next_head_s;
      if (drop_s) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Testbench for ps2_key_event (DEPTH=4, SUPPRESS_REPEAT=1).
// Directed scenarios use constant expectations; the randomized phase is
// compared against a token-level reference model kept in this file.
module tb_ps2_key_event;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scancode;
  logic       flag;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic [2:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  ps2_key_event #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
    .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_release(ev_release), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  wire [9:0] head = {ev_ext, ev_release, ev_code};

  // ---------------- reference model ----------------
  logic [9:0] mq[$];
  bit         m_pend_v = 1'b0;
  logic [9:0] m_pend = 10'h000;
  bit         m_ext = 1'b0;
  bit         m_rel = 1'b0;
  int         m_pause = 0;
  bit         m_hv = 1'b0;
  bit         m_hext = 1'b0;
  logic [7:0] m_hcode = 8'h00;
  bit         m_ovf = 1'b0;

  task automatic model_emit(input bit e, input bit r, input logic [7:0] c);
    m_pend_v = 1'b1;
    m_pend   = {e, r, c};
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) model_emit(1'b0, 1'b0, 8'hE1);
    end else if (b == 8'hE0) begin
      if (!m_ext) m_rel = 1'b0;
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (!m_ext && !m_rel && b == 8'hE1) begin
      m_pause = 7;
    end else if (!m_ext && !m_rel &&
                 (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
      m_pause = 0;
    end else begin
      if (!m_rel) begin
        if (!(m_hv && m_hext == m_ext && m_hcode == b)) begin
          model_emit(m_ext, 1'b0, b);
          m_hv = 1'b1; m_hext = m_ext; m_hcode = b;
        end
      end else begin
        model_emit(m_ext, 1'b1, b);
        if (m_hv && m_hext == m_ext && m_hcode == b) m_hv = 1'b0;
      end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (reset !== 1'b1) begin
        mq.delete();
        m_pend_v = 1'b0; m_ext = 1'b0; m_rel = 1'b0; m_pause = 0;
        m_hv = 1'b0; m_ovf = 1'b0;
      end else begin
        if (mq.size() != 0 && ev_ready) void'(mq.pop_front());
        if (m_pend_v) begin
          if (mq.size() < DEPTH) mq.push_back(m_pend);
          else m_ovf = 1'b1;
        end
        m_pend_v = 1'b0;
        if (flag) model_byte(scancode);
      end
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scancode = b;
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    scancode = 8'h00;
  endtask

  task automatic pop1;
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0; flag = 1'b0; ev_ready = 1'b0; scancode = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({ev_valid, head, count, overflow} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b head=%h count=%0d ovf=%b expected all zero",
               ev_valid, head, count, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send(8'h1C);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: got valid=%b expected 0", ev_valid);
    end
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b1 || head !== 10'h01C) begin
      errors++; $display("FAIL latency_two_edges: got valid=%b head=%h expected 1/01c", ev_valid, head);
    end
    send(8'hF0); send(8'h1C);
    @(negedge clk);
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("FAIL basic_count: got %0d expected 2", count);
    end
    pop1;
    checks++;
    if (head !== 10'h11C || count !== 3'd1) begin
      errors++; $display("FAIL basic_break: got head=%h count=%0d expected 11c/1", head, count);
    end
    pop1;
    checks++;
    if (ev_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL basic_empty: got valid=%b count=%0d expected 0/0", ev_valid, count);
    end
  endtask

  task automatic test_ext;
    logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) send(seq[i]);
    @(negedge clk);
    checks++;
    if (count !== 3'd2 || head !== 10'h275) begin
      errors++; $display("FAIL ext_make: got count=%0d head=%h expected 2/275", count, head);
    end
    pop1;
    checks++;
    if (head !== 10'h375 || count !== 3'd1) begin
      errors++; $display("FAIL ext_break: got head=%h count=%0d expected 375/1", head, count);
    end
    pop1;
  endtask

  task automatic test_repeat;
    logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    logic [9:0] exp [3] = '{10'h01C, 10'h11C, 10'h01C};
    foreach (seq[i]) send(seq[i]);
    @(negedge clk);
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL repeat_count: got %0d expected 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ev_valid !== 1'b1 || head !== exp[i]) begin
        errors++; $display("FAIL repeat_event%0d: got valid=%b head=%h expected 1/%h", i, ev_valid, head, exp[i]);
      end
      pop1;
    end
  endtask

  task automatic test_pause;
    logic [7:0] seq [7] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
    foreach (seq[i]) send(seq[i]);
    @(negedge clk);
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL pause_early: got count=%0d expected 0", count);
    end
    send(8'h77);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || head !== 10'h0E1) begin
      errors++; $display("FAIL pause_event: got count=%0d head=%h expected 1/0e1", count, head);
    end
    pop1;
  endtask

  task automatic test_overflow;
    logic [7:0] seq [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [9:0] exp [4] = '{10'h01D, 10'h024, 10'h02D, 10'h033};
    foreach (seq[i]) send(seq[i]);
    @(negedge clk);
    checks++;
    if (count !== 3'd4 || overflow !== 1'b1 || head !== 10'h015) begin
      errors++; $display("FAIL ovf_full: got count=%0d ovf=%b head=%h expected 4/1/015", count, overflow, head);
    end
    // push into a full FIFO on the same edge as a pop
    send(8'h33);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    checks++;
    if (count !== 3'd4 || head !== 10'h01D) begin
      errors++; $display("FAIL ovf_push_pop: got count=%0d head=%h expected 4/01d", count, head);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ev_valid !== 1'b1 || head !== exp[i]) begin
        errors++; $display("FAIL ovf_drain%0d: got valid=%b head=%h expected 1/%h", i, ev_valid, head, exp[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (ev_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_after_drain: got valid=%b count=%0d ovf=%b expected 0/0/1", ev_valid, count, overflow);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || ev_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL async_reset: got count=%0d valid=%b ovf=%b expected 0/0/0", count, ev_valid, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    send(8'h1C);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || head !== 10'h01C || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_reparse: got count=%0d head=%h ovf=%b expected 1/01c/0", count, head, overflow);
    end
    pop1;
  endtask

  task automatic test_random;
    logic [7:0] pool [10] = '{8'h1C, 8'h1C, 8'hF0, 8'hF0, 8'hE0, 8'h32, 8'h4B, 8'hAA, 8'h75, 8'h15};
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (count !== mq.size()) begin
        errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, count, mq.size());
      end
      checks++;
      if (ev_valid !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_valid@%0d: got %b expected %b", c, ev_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        checks++;
        if (head !== mq[0]) begin
          errors++; $display("FAIL rand_head@%0d: got %h expected %h", c, head, mq[0]);
        end
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL rand_overflow@%0d: got %b expected %b", c, overflow, m_ovf);
      end
      if (flag) begin
        flag = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        flag = 1'b1;
        scancode = pool[$urandom_range(0, 9)];
      end
      ev_ready = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    flag = 1'b0;
    ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext();
    test_repeat();
    test_pause();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
